// File: rtl/mem_stall_if.sv
// Bundles the MEM-stage access request coming from the pipeline and the
// stall/done/statistics results that the stall unit returns.
interface mem_stall_if #(
  parameter int STAT_W = 16
);
  logic [1:0]        mem_MemWr;
  logic              mem_ready;
  logic              flush;
  logic              mem_stall;
  logic              mem_done;
  logic              busy;
  logic [STAT_W-1:0] stall_cnt;

  // The pipeline side issues the request and observes the stall outputs.
  modport master (
    output mem_MemWr, mem_ready, flush,
    input  mem_stall, mem_done, busy, stall_cnt
  );

  // The stall unit consumes the request and produces the stall outputs.
  modport slave (
    input  mem_MemWr, mem_ready, flush,
    output mem_stall, mem_done, busy, stall_cnt
  );
endinterface

// File: rtl/mem_stall_unit.sv
// Multi-cycle memory stall generator: holds the front of the pipeline for a
// per-access-type number of cycles, then pulses done for one cycle.
module mem_stall_unit #(
  parameter int LOAD_CYCLES  = 1,
  parameter int STORE_CYCLES = 1,
  parameter int RMW_CYCLES   = 2,
  parameter int CNT_W        = 4,
  parameter int STAT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_stall_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stall length per access code; code 0 (no access) maps to zero cycles.
  localparam int CYCLES [4] = '{0, LOAD_CYCLES, STORE_CYCLES, RMW_CYCLES};

  logic [CNT_W-1:0]  cycle_lut [4];
  logic [CNT_W-1:0]  access_len;
  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              stall_reg, done_reg;
  logic [STAT_W-1:0] stat_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lut
      assign cycle_lut[gi] = CNT_W'(CYCLES[gi]);
    end
  endgenerate

  assign access_len = cycle_lut[bus.mem_MemWr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      stall_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stall_reg <= (state_next == WAIT);
      done_reg  <= (state_next == DONE);
    end
  end

  // Flush outranks everything; in WAIT a dropped request aborts silently,
  // otherwise expiry or an early ready finishes through DONE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (bus.flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (access_len != '0) begin
            state_next = WAIT;
            cnt_next   = access_len - CNT_W'(1);
          end
        end
        WAIT: begin
          if (bus.mem_MemWr == 2'b00) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if ((cnt_reg == '0) || bus.mem_ready) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Statistics count cycles actually spent stalled and stick at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reg <= '0;
    end else if (stall_reg && (stat_reg != '1)) begin
      stat_reg <= stat_reg + STAT_W'(1);
    end
  end

  assign bus.mem_stall = stall_reg;
  assign bus.mem_done  = done_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.stall_cnt = stat_reg;

endmodule

// File: tb/tb_mem_stall_unit.sv
// Drives three differently parameterised stall units with one shared random
// request stream and compares each against a cycle-count reference model.
module tb_mem_stall_unit;

  logic clk;
  logic rst_n;

  mem_stall_if #(.STAT_W(16)) bus_a ();
  mem_stall_if #(.STAT_W(4))  bus_b ();
  mem_stall_if #(.STAT_W(8))  bus_c ();

  mem_stall_unit #(
    .LOAD_CYCLES(1), .STORE_CYCLES(1), .RMW_CYCLES(2), .CNT_W(4), .STAT_W(16)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  mem_stall_unit #(
    .LOAD_CYCLES(3), .STORE_CYCLES(0), .RMW_CYCLES(5), .CNT_W(4), .STAT_W(4)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  mem_stall_unit #(
    .LOAD_CYCLES(1), .STORE_CYCLES(3), .RMW_CYCLES(2), .CNT_W(4), .STAT_W(8)
  ) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int step_no  = 0;

  // Reference model: stall cycles still owed, pending done pulse, statistics.
  int ncyc [3][4] = '{'{0, 1, 1, 2}, '{0, 3, 0, 5}, '{0, 1, 3, 2}};
  int smax [3]    = '{65535, 15, 255};
  string iname [3] = '{"a", "b", "c"};
  int m_left [3];
  bit m_done [3];
  int m_scnt [3];

  logic [1:0] cur_code;
  logic       cur_ready;
  logic       cur_flush;

  int got_s [3];
  int got_d [3];
  int got_b [3];
  int got_c [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic r, input logic f);
    cur_code  = c;
    cur_ready = r;
    cur_flush = f;
    bus_a.mem_MemWr = c; bus_a.mem_ready = r; bus_a.flush = f;
    bus_b.mem_MemWr = c; bus_b.mem_ready = r; bus_b.flush = f;
    bus_c.mem_MemWr = c; bus_c.mem_ready = r; bus_c.flush = f;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_left[i] = 0;
      m_done[i] = 1'b0;
      m_scnt[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (m_left[i] > 0 && m_scnt[i] < smax[i]) m_scnt[i]++;
      if (cur_flush) begin
        m_left[i] = 0;
        m_done[i] = 1'b0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (m_left[i] > 0) begin
        if (cur_code == 2'b00) begin
          m_left[i] = 0;
        end else begin
          m_left[i]--;
          if (m_left[i] == 0 || cur_ready) begin
            m_left[i] = 0;
            m_done[i] = 1'b1;
          end
        end
      end else begin
        m_left[i] = ncyc[i][cur_code];
      end
    end
  endtask

  task automatic sample();
    got_s[0] = int'(bus_a.mem_stall); got_d[0] = int'(bus_a.mem_done);
    got_b[0] = int'(bus_a.busy);      got_c[0] = int'(bus_a.stall_cnt);
    got_s[1] = int'(bus_b.mem_stall); got_d[1] = int'(bus_b.mem_done);
    got_b[1] = int'(bus_b.busy);      got_c[1] = int'(bus_b.stall_cnt);
    got_s[2] = int'(bus_c.mem_stall); got_d[2] = int'(bus_c.mem_done);
    got_b[2] = int'(bus_c.busy);      got_c[2] = int'(bus_c.stall_cnt);
  endtask

  task automatic compare_all();
    sample();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_stall@%0d", iname[i], step_no), got_s[i], (m_left[i] > 0) ? 1 : 0);
      chk($sformatf("%s_done@%0d",  iname[i], step_no), got_d[i], m_done[i] ? 1 : 0);
      chk($sformatf("%s_busy@%0d",  iname[i], step_no), got_b[i],
          (m_left[i] > 0 || m_done[i]) ? 1 : 0);
      chk($sformatf("%s_cnt@%0d",   iname[i], step_no), got_c[i], m_scnt[i]);
      chk($sformatf("%s_excl@%0d",  iname[i], step_no), got_s[i] & got_d[i], 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    $display("step %0d code=%0d rdy=%0d fl=%0d | a s%0d d%0d c%0d | b s%0d d%0d c%0d | c s%0d d%0d c%0d",
             step_no, cur_code, cur_ready, cur_flush,
             got_s[0], got_d[0], got_c[0], got_s[1], got_d[1], got_c[1],
             got_s[2], got_d[2], got_c[2]);
    step_no++;
  endtask

  // Asserts reset between edges and expects every output to drop at once.
  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    sample();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_rst_stall@%0d", iname[i], step_no), got_s[i], 0);
      chk($sformatf("%s_rst_done@%0d",  iname[i], step_no), got_d[i], 0);
      chk($sformatf("%s_rst_busy@%0d",  iname[i], step_no), got_b[i], 0);
      chk($sformatf("%s_rst_cnt@%0d",   iname[i], step_no), got_c[i], 0);
    end
    $display("reset pulse at step %0d", step_no);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 1'b0, 1'b0);
    model_reset();
    #12;
    sample();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_por_stall", iname[i]), got_s[i], 0);
      chk($sformatf("%s_por_done",  iname[i]), got_d[i], 0);
      chk($sformatf("%s_por_busy",  iname[i]), got_b[i], 0);
      chk($sformatf("%s_por_cnt",   iname[i]), got_c[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // RMW held: unit a stalls two cycles then pulses done.
    drive(2'b11, 1'b0, 1'b0);
    step(); step(); step();
    chk("a_rmw_cnt", int'(bus_a.stall_cnt), 2);
    chk("a_rmw_done", int'(bus_a.mem_done), 1);
    for (int k = 0; k < 5; k++) step();

    // Load held long enough to saturate the narrow counter of unit b.
    drive(2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) step();
    chk("b_saturated", int'(bus_b.stall_cnt), 15);

    // Store on c (three cycles), then flush mid-wait and a dropped request.
    drive(2'b00, 1'b0, 1'b0); step(); step();
    drive(2'b10, 1'b0, 1'b0); step(); step();
    drive(2'b10, 1'b0, 1'b1); step();
    drive(2'b10, 1'b0, 1'b0); step(); step();
    drive(2'b00, 1'b0, 1'b0); step(); step();
    chk("b_store_never_stalls", int'(bus_b.busy), 0);

    // Store again on c, reset in the middle of its wait.
    drive(2'b10, 1'b0, 1'b0); step(); step();
    mid_reset();
    step(); step();

    // Early-ready on unit b's five-cycle RMW.
    drive(2'b00, 1'b0, 1'b0); step();
    drive(2'b11, 1'b0, 1'b0); step(); step();
    drive(2'b11, 1'b1, 1'b0); step();
    drive(2'b11, 1'b0, 1'b0); step(); step();

    for (int k = 0; k < 1500; k++) begin
      logic [1:0] c;
      c = cur_code;
      if ($urandom_range(0, 5) == 0) c = 2'($urandom_range(0, 3));
      drive(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      step();
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
